// File: rtl/router_pkt_tx.sv
// router_pkt_tx: source-side packet transmitter for a router input port.
// Loads a whole payload into an internal buffer, then sends header, payload
// and parity back to back, holding whenever the router raises busy.
// Optional build macro ROUTER_TX_PARITY_INJ_EN adds the parity_inj input,
// which inverts the transmitted parity byte of the requested packet.
module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] payload_len,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    input  logic       busy,
`ifdef ROUTER_TX_PARITY_INJ_EN
    input  logic       parity_inj,
`endif
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_busy,
    output logic       done,
    output logic       err
);

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] parity;
    logic [DATA_W-1:0] parity_out;
    logic [5:0]        len_r;
    logic [5:0]        load_cnt;
    logic [5:0]        tx_idx;
    logic [DATA_W-1:0] pbuf [0:MAX_LEN-1];

    logic req_bad;
    logic load_xfer;
    logic load_last;

    assign src_ready = (state == S_LOAD);
    assign tx_busy   = (state != S_IDLE);
    assign load_xfer = src_ready && src_valid;
    assign load_last = (load_cnt == (len_r - 6'd1));

    // A request is refused for an empty payload, an oversize payload or the
    // non-existent port 3.
    assign req_bad = (payload_len == 6'd0)
                  || (int'(payload_len) > MAX_LEN)
                  || (dest_addr == 2'd3);

`ifdef ROUTER_TX_PARITY_INJ_EN
    logic inj_r;

    // Capture the corruption request together with an accepted start
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inj_r <= 1'b0;
        end else if (state == S_IDLE && start && !req_bad) begin
            inj_r <= parity_inj;
        end
    end

    assign parity_out = parity ^ {DATA_W{inj_r}};
`else
    assign parity_out = parity;
`endif

    // Payload buffer: written only while loading, contents need no reset
    always_ff @(posedge clock) begin
        if (load_xfer) begin
            pbuf[load_cnt] <= src_data;
        end
    end

    // Packet sequencer with registered router-side outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            data_out  <= '0;
            pkt_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            hdr       <= '0;
            parity    <= '0;
            len_r     <= '0;
            load_cnt  <= '0;
            tx_idx    <= '0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (req_bad) begin
                            err <= 1'b1;
                        end else begin
                            hdr      <= {payload_len, dest_addr};
                            parity   <= {payload_len, dest_addr};
                            len_r    <= payload_len;
                            load_cnt <= 6'd0;
                            state    <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_xfer) begin
                        parity   <= parity ^ src_data;
                        load_cnt <= load_cnt + 6'd1;
                        // Header goes out on the same edge the last byte lands
                        if (load_last) begin
                            data_out  <= hdr;
                            pkt_valid <= 1'b1;
                            state     <= S_HEADER;
                        end
                    end
                end
                S_HEADER: begin
                    if (!busy) begin
                        data_out <= pbuf[0];
                        tx_idx   <= 6'd1;
                        state    <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        if (tx_idx == len_r) begin
                            data_out  <= parity_out;
                            pkt_valid <= 1'b0;
                            state     <= S_PARITY;
                        end else begin
                            data_out <= pbuf[tx_idx];
                            tx_idx   <= tx_idx + 6'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        data_out <= '0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: scoreboard bench for router_pkt_tx. The driver pushes the
// expected router byte stream of each packet; a monitor pops and compares
// every byte the router consumes.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dest_addr = 2'd0;
    logic [5:0] payload_len = 6'd0;
    logic [7:0] src_data = 8'd0;
    logic       src_valid = 1'b0;
    logic       busy = 1'b0;
    logic       src_ready;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_busy;
    logic       done;
    logic       err;
`ifdef ROUTER_TX_PARITY_INJ_EN
    logic       parity_inj = 1'b0;
`endif

    router_pkt_tx #(.MAX_LEN(63)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dest_addr  (dest_addr),
        .payload_len(payload_len),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .busy       (busy),
`ifdef ROUTER_TX_PARITY_INJ_EN
        .parity_inj (parity_inj),
`endif
        .data_out   (data_out),
        .pkt_valid  (pkt_valid),
        .tx_busy    (tx_busy),
        .done       (done),
        .err        (err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] d;
        logic       pv;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pl [0:63];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         done_cnt = 0;
    int         exp_done = 0;
    int         err_cnt = 0;
    int         exp_err = 0;
    int         busy_mode = 0;
    logic       busy_force = 1'b0;
    bit         last_parity = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) if (!reset && err) err_cnt <= err_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Router stall generator
    initial forever begin
        @(posedge clock);
        #2;
        if (busy_mode == 1)      busy = ($urandom_range(0, 3) == 0);
        else if (busy_mode == 2) busy = busy_force;
        else                     busy = 1'b0;
    end

    // Monitor: a byte is consumed when the block is sending and busy is low
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (!reset && tx_busy && !src_ready && !done && !busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte actual=%0h expected=none", data_out);
            end else begin
                e = exp_q.pop_front();
                chk("data_out", data_out, e.d);
                chk("pkt_valid", pkt_valid, e.pv);
                last_parity = !e.pv;
            end
        end
        if (!reset && done) begin
            chk("done_after_parity", last_parity, 1);
            last_parity = 1'b0;
            done_cnt++;
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    // Queue the expected stream from the packet definition, then drive load
    task automatic send_pkt(input int len, input logic [1:0] addr, input bit inj, input int vmode);
        logic [7:0] hdr;
        logic [7:0] par;
        int         i;
        int         t;
        bit         xfer;
        hdr = {6'(len), addr};
        par = hdr;
        exp_q.push_back('{d: hdr, pv: 1'b1});
        for (int k = 0; k < len; k++) begin
            par = par ^ pl[k];
            exp_q.push_back('{d: pl[k], pv: 1'b1});
        end
        exp_q.push_back('{d: (inj ? ~par : par), pv: 1'b0});
        exp_done++;
        @(posedge clock);
        #1;
        start       = 1'b1;
        payload_len = 6'(len);
        dest_addr   = addr;
`ifdef ROUTER_TX_PARITY_INJ_EN
        parity_inj  = inj;
`endif
        @(posedge clock);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
        i = 0;
        t = 0;
        while (i < len && t < 2000) begin
            if (vmode == 0)      src_valid = 1'b1;
            else if (vmode == 1) src_valid = (t % 2 == 0);
            else                 src_valid = $urandom_range(0, 1);
            if (vmode == 2) begin
                start       = $urandom_range(0, 1);
                payload_len = 6'd0;
                dest_addr   = 2'd3;
            end
            src_data = pl[i];
            xfer = src_valid && src_ready;
            @(posedge clock);
            #1;
            if (xfer) i++;
            t++;
        end
        src_valid = 1'b0;
        start     = 1'b0;
        if (t >= 2000) chk("load_timeout", i, len);
    endtask

    task automatic wait_done(input int exp_delta);
        int t;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!done && t < 1000);
        if (!done) chk("done_timeout", done, 1);
        else if (exp_delta >= 0) chk("done_time", cyc - start_cyc, exp_delta);
    endtask

    task automatic reject(input int len, input logic [1:0] addr);
        @(posedge clock);
        #1;
        start       = 1'b1;
        payload_len = 6'(len);
        dest_addr   = addr;
        exp_err++;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("reject_tx_busy", tx_busy, 0);
        chk("reject_pkt_valid", pkt_valid, 0);
        @(posedge clock);
        #1;
        chk("err_one_cycle", err, 0);
        chk("reject_tx_busy2", tx_busy, 0);
    endtask

    initial begin
        #1;
        reset = 1'b1;
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_src_ready", src_ready, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic packet, no stalls
        pl[0] = 8'hA5; pl[1] = 8'h3C; pl[2] = 8'h0F;
        send_pkt(3, 2'd1, 1'b0, 0);
        wait_done(8);

        // Same packet, router stalls two cycles on the first payload byte
        busy_mode  = 2;
        busy_force = 1'b0;
        fork
            begin
                send_pkt(3, 2'd1, 1'b0, 0);
                wait_done(10);
            end
            begin
                int t;
                t = 0;
                while (!(pkt_valid && data_out == 8'hA5) && t < 200) begin
                    @(posedge clock);
                    #1;
                    t++;
                end
                busy_force = 1'b1;
                repeat (2) begin
                    @(posedge clock);
                    #1;
                end
                busy_force = 1'b0;
            end
        join
        busy_mode = 0;

        // Refused requests
        reject(0, 2'd1);
        reject(5, 2'd3);

        // Maximum length with a toggling source
        for (int k = 0; k < 63; k++) pl[k] = 8'(k);
        send_pkt(63, 2'd2, 1'b0, 1);
        wait_done(-1);

        // Reset in the middle of the payload
        for (int k = 0; k < 10; k++) pl[k] = 8'($urandom);
        send_pkt(10, 2'd0, 1'b0, 0);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        exp_q.delete();
        last_parity = 1'b0;
        exp_done--;
        #1;
        chk("abort_data_out", data_out, 0);
        chk("abort_pkt_valid", pkt_valid, 0);
        chk("abort_tx_busy", tx_busy, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        pl[0] = 8'h55;
        send_pkt(1, 2'd0, 1'b0, 0);
        wait_done(4);

`ifdef ROUTER_TX_PARITY_INJ_EN
        pl[0] = 8'hA5; pl[1] = 8'h3C; pl[2] = 8'h0F;
        send_pkt(3, 2'd1, 1'b1, 0);
        wait_done(8);
        send_pkt(3, 2'd1, 1'b0, 0);
        wait_done(8);
`endif

        // Random traffic with random stalls and source gaps
        busy_mode = 1;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 0) reject(0, 2'($urandom_range(0, 3)));
                else                           reject($urandom_range(0, 63), 2'd3);
            end else begin
                int len;
                len = $urandom_range(1, 63);
                for (int k = 0; k < len; k++) pl[k] = 8'($urandom);
                send_pkt(len, 2'($urandom_range(0, 2)), 1'b0, $urandom_range(0, 2));
                wait_done(-1);
            end
        end
        busy_mode = 0;
        repeat (5) @(posedge clock);
        #1;

        chk("leftover_bytes", exp_q.size(), 0);
        chk("done_count", done_cnt, exp_done);
        chk("err_count", err_cnt, exp_err);
        chk("idle_at_end", tx_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the router's input port. It accepts a destination address, a payload length and a stream of payload bytes from a client, and buffers the whole payload internally. It then emits a gap-free packet on the router input protocol: header byte, payload bytes, then parity byte, stalling whenever the router asserts `busy`. It is the source-side counterpart to the per-port output FIFOs and drives the router's `data_in`/`pkt_valid`/`busy` interface.

## Interface
- `MAX_LEN`, 63: largest accepted payload length in bytes and the depth of the internal payload buffer (1..63).
- `clock` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request to send a packet; sampled only in IDLE.
- `dest_addr` input 2: destination port, 0..2 valid; sampled with `start`.
- `payload_len` input 6: payload byte count, 1..`MAX_LEN`; sampled with `start`.
- `src_data` input 8: payload byte from the client.
- `src_valid` input 1: `src_data` is valid.
- `src_ready` output 1: combinational, high in LOAD; a byte transfers on an edge where `src_valid` and `src_ready` are both high.
- `busy` input 1: router stall; high means no byte is consumed this cycle.
- `data_out` output 8: registered byte to the router.
- `pkt_valid` output 1: registered; high during header and payload, low during parity.
- `tx_busy` output 1: combinational, high whenever the state is not IDLE.
- `done` output 1: registered one-cycle pulse after the parity byte is consumed.
- `err` output 1: registered one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, DONE.
- Reset (asynchronous): state IDLE, `data_out`=0x00, `pkt_valid`=0, `done`=0, `err`=0, counters and parity cleared. Buffer contents are don't-care.
- IDLE, on `start`:
  - If `payload_len`==0, `payload_len`>`MAX_LEN` or `dest_addr`==3: pulse `err`, stay in IDLE.
  - Otherwise: latch header = {`payload_len`,`dest_addr`}, set parity = header, set load count = 0, go to LOAD.
- LOAD, on each accepted source byte:
  - buf[count] ← `src_data`, parity ^= `src_data`, count increments.
  - On acceptance of byte `len`-1: load `data_out` ← header and `pkt_valid` ← 1, go to HEADER.
  - `src_valid` gaps are allowed and simply wait.
- HEADER, on an edge with `busy`=0: `data_out` ← buf[0], idx ← 1, go to PAYLOAD.
- PAYLOAD, on an edge with `busy`=0:
  - If idx==len: `data_out` ← parity, `pkt_valid` ← 0, go to PARITY.
  - Otherwise: `data_out` ← buf[idx], idx increments.
- PARITY, on an edge with `busy`=0: `data_out` ← 0x00, `done` ← 1, go to DONE.
- DONE: `done` ← 0, go to IDLE.
- While `busy`=1, the state, `data_out` and `pkt_valid` hold unchanged.
- Parity is the 8-bit XOR of the header and all payload bytes. Counters and indexes are 6-bit and never wrap, because len ≤ 63.
- `start` outside IDLE is ignored and does not produce `err`.

## Timing
- With `start` at edge 0 and `src_valid` and `busy` held at their ideal values:
  - Load occupies edges 1..len.
  - The header is visible after edge len.
  - Payload bytes are visible after edges len+1..2len.
  - Parity is visible after edge 2len+1.
  - `done` is high after edge 2len+2.
  - IDLE is reached after edge 2len+3.
- Each `busy` cycle while sending adds exactly one cycle. Each `src_valid`=0 cycle in LOAD adds exactly one cycle.
- Between HEADER and PARITY there are no bubbles: the router sees len+2 consecutive bytes, apart from `busy` holds.
- Reset asserted mid-packet aborts the packet immediately. Outputs take their reset values asynchronously; no `done` is produced.

## Configuration
- `ROUTER_TX_PARITY_INJ_EN` defined:
  - Adds input `parity_inj` (1 bit), sampled with an accepted `start`.
  - When it was 1, the transmitted parity byte is ~parity; the header and payload are unaffected.
- `ROUTER_TX_PARITY_INJ_EN` not defined: the port is absent and the parity byte is always correct.

## Test plan
- len=3, addr=1, payload A5,3C,0F, `busy`=0 → byte stream 0D, A5, 3C, 0F, then 9B with `pkt_valid` low. `done` is high after edge 8.
- Same packet with `busy`=1 for 2 cycles during byte A5 → A5 is held for 3 cycles and the stream is unchanged. `done` is high after edge 10.
- `payload_len`=0, then `dest_addr`=3 → `err` pulses once for each request, `tx_busy` stays 0, `pkt_valid` stays 0.
- len=63, addr=2, payload bytes 0..62, `src_valid` toggling every other cycle → header FE, then 63 payload bytes in order with no gaps, then parity = FE ^ XOR(0..62).
- Reset asserted during PAYLOAD → `data_out`=00 and `pkt_valid`=0 immediately. A following `start` (len=1, addr=0, payload 55) sends 04, 55, 51.
- With `ROUTER_TX_PARITY_INJ_EN` defined and `parity_inj`=1 on the first test packet → parity byte 64.
